ysyx_23060184_exu_ctrl: RTL
===========================

# ysyx_23060184_exu_ctrl

Handshake and sequencing controller for the execute stage. It decides when the EXU accepts an instruction from ID and when the result is presented to MEM. It issues start, abort and enable controls to the shared iterative multiply/divide unit, counts its fixed latency, and generates the EX result-register capture strobe. It sits between the ID→EX (Dvalid/Eready) and EX→MEM (Evalid/Mready) handshakes, and it honours the pipeline-wide stall and branch flush.

## Interface
- MUL_LAT, default 3: multiply latency in cycles from accept to result capture; legal range 2..63.
- DIV_LAT, default 33: divide/remainder latency in cycles from accept to result capture; legal range 2..63.
- clk, in, 1: single clock; all state is updated on the rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- Dvalid, in, 1: ID holds a valid instruction for EX.
- OpClass, in, 2: class of the offered instruction; 0 = single-cycle ALU, 1 = MUL, 2 = DIV, 3 = treated as single-cycle.
- DivZero, in, 1: the offered DIV has a zero divisor; qualified by OpClass==2.
- Stall, in, 1: global freeze.
- Flush, in, 1: squash of the EX contents, driven by the branch/jump redirect.
- Mready, in, 1: MEM accepts the EX result.
- Eready, out, 1: EX accepts this cycle.
- Evalid, out, 1: the EX result register holds a valid result.
- MduStart, out, 1: one-cycle pulse that launches the multiply/divide unit.
- MduAbort, out, 1: one-cycle pulse that kills the in-flight multiply/divide operation.
- MduEn, out, 1: clock enable for the multiply/divide unit; equals !Stall.
- ResultWe, out, 1: load strobe for the EX result register.
- Busy, out, 1: a multi-cycle operation is in flight.

## Operation
- States: IDLE, EXEC (multi-cycle operation counting), HOLD (result valid, waiting for MEM).
- Accept condition: Fire = Dvalid & Eready.
- Eready = !Stall & !Flush & (IDLE | (HOLD & Mready)).
- Single-cycle accept (OpClass 0 or 3, or DIV with DivZero):
  - ResultWe is asserted in the same cycle as Fire.
  - Next state is HOLD.
- Multi-cycle accept (MUL, or DIV without DivZero):
  - MduStart = Fire in the same cycle; ResultWe = 0.
  - Counter Cnt is loaded with LAT-2.
  - Next state is EXEC.
- EXEC:
  - Cnt decrements each non-stalled cycle.
  - When Cnt==0: ResultWe=1 and next state is HOLD.
- HOLD:
  - Evalid=1.
  - On Mready with no Fire: next state is IDLE.
  - On Mready with Fire: back-to-back; the accept rules above apply in the same cycle.
- Busy = (state==EXEC).
- Stall:
  - State, Cnt and Evalid are frozen.
  - ResultWe, MduStart and Eready are 0.
  - Mready is ignored.
- Flush:
  - From EXEC: MduAbort=1.
  - From any state: next state is IDLE, Evalid drops next cycle, ResultWe=0.
  - Flush overrides Stall.
- Cnt width is 6 bits; it is never decremented below 0.
- OpClass/DivZero are sampled only when Fire is asserted.

## Timing
- Reset values:
  - State is IDLE and Cnt is 0.
  - Evalid, Busy, MduStart, MduAbort and ResultWe are 0.
  - Eready is 1 when Stall=0 and Flush=0.
  - MduEn is 1 when Stall=0.
- Single-cycle operation: accept in cycle T, Evalid high from T+1.
- Multi-cycle operation: accept in cycle T, ResultWe in cycle T+LAT-1, Evalid from T+LAT.
- Stall cycles add directly to latency.
- Single-cycle throughput: one instruction per cycle while Mready=1.
- Evalid stays high until the cycle after Mready=1 with Stall=0, or the cycle after Flush.
- Reset asserted mid-EXEC: immediate return to IDLE. MduAbort is not pulsed; the multiply/divide unit shares rst.
- Flush and Dvalid in the same cycle: no accept.
- Stall and Mready in the same cycle: no handoff; Evalid is held.

## Structure
- Shared package holds:
  - OpClass encodings: OP_ALU=0, OP_MUL=1, OP_DIV=2.
  - State encoding: 2-bit IDLE=0, EXEC=1, HOLD=2.
  - Default MUL_LAT and DIV_LAT values.
- No sub-modules: a single FSM plus a counter.

## Test plan
- Reset, then an ALU op with Dvalid=1 and Mready=1: Eready=1, ResultWe in cycle 0, Evalid in cycle 1. Five consecutive ALU ops give five Evalid cycles with no bubbles.
- MUL with MUL_LAT=3, accepted in cycle 0:
  - MduStart in cycle 0.
  - Busy in cycles 1-2; Eready=0 in cycles 1-2.
  - ResultWe in cycle 2, Evalid in cycle 3.
- DIV with DIV_LAT=33:
  - DivZero=0: Evalid at cycle 33.
  - DivZero=1: Evalid at cycle 1, MduStart never asserted.
- MUL with Stall high for 4 cycles during EXEC: Cnt is frozen and MduEn=0, then Evalid arrives at cycle 7.
- Flush at cycle 10 of a DIV: MduAbort pulses in cycle 10, state is IDLE at cycle 11, Evalid never rises, and an accept is possible in cycle 11.
- In HOLD with Mready=0 for 3 cycles: Evalid stays 1 and Eready=0. When Mready=1 together with Dvalid, the handoff and the new accept happen in the same cycle.

Source files
------------

// File: rtl/ysyx_23060184_exu_ctrl_pkg.sv
// Shared encodings and defaults for the execute-stage handshake controller.
package ysyx_23060184_exu_ctrl_pkg;

    localparam logic [1:0] OP_ALU = 2'd0;
    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_DIV = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam int MUL_LAT_DEF = 3;
    localparam int DIV_LAT_DEF = 33;
    localparam int CNT_W       = 6;

    // Class 3 runs as ALU; a divide by zero needs no iteration.
    function automatic logic is_single(input logic [1:0] op, input logic dz);
        return (op == OP_ALU) || (op == 2'd3) || ((op == OP_DIV) && dz);
    endfunction

endpackage

// File: rtl/ysyx_23060184_exu_ctrl_if.sv
// ID->EX / EX->MEM handshake, pipeline control and mul/div control bundle.
interface ysyx_23060184_exu_ctrl_if;
    logic       Dvalid;
    logic [1:0] OpClass;
    logic       DivZero;
    logic       Stall;
    logic       Flush;
    logic       Mready;
    logic       Eready;
    logic       Evalid;
    logic       MduStart;
    logic       MduAbort;
    logic       MduEn;
    logic       ResultWe;
    logic       Busy;

    modport slave (
        input  Dvalid, OpClass, DivZero, Stall, Flush, Mready,
        output Eready, Evalid, MduStart, MduAbort, MduEn, ResultWe, Busy
    );

    modport master (
        output Dvalid, OpClass, DivZero, Stall, Flush, Mready,
        input  Eready, Evalid, MduStart, MduAbort, MduEn, ResultWe, Busy
    );
endinterface

// File: rtl/ysyx_23060184_exu_ctrl.sv
// Execute-stage sequencer: accept from ID, time the mul/div unit, hold result for MEM.
module ysyx_23060184_exu_ctrl
    import ysyx_23060184_exu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_23060184_exu_ctrl_if.slave   bus
);

    // Counter runs LAT-2 .. 0 so the capture lands in cycle T+LAT-1.
    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 2);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              idle, exec, hold;
    logic              fire, single, done;
    logic [CNT_W-1:0]  ld;

    assign idle   = (state == S_IDLE);
    assign exec   = (state == S_EXEC);
    assign hold   = (state == S_HOLD);

    assign bus.Eready = !bus.Stall && !bus.Flush && (idle || (hold && bus.Mready));
    assign fire       = bus.Dvalid && bus.Eready;
    assign single     = is_single(bus.OpClass, bus.DivZero);
    assign done       = exec && (cnt == '0) && !bus.Stall && !bus.Flush;
    assign ld         = (bus.OpClass == OP_MUL) ? MUL_LD : DIV_LD;

    assign bus.ResultWe = (fire && single) || done;
    assign bus.MduStart = fire && !single;
    assign bus.MduAbort = bus.Flush && exec;
    assign bus.MduEn    = !bus.Stall;
    assign bus.Busy     = exec;
    assign bus.Evalid   = hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (bus.Flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (!bus.Stall) begin
            // Fire is only possible from IDLE or a handing-off HOLD, so it takes priority.
            if (fire) begin
                state <= single ? S_HOLD : S_EXEC;
                cnt   <= single ? '0 : ld;
            end else begin
                case (state)
                    S_EXEC: begin
                        if (cnt == '0) state <= S_HOLD;
                        else           cnt   <= cnt - CNT_W'(1);
                    end
                    S_HOLD: if (bus.Mready) state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
